// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding and register constants for the hazard controller
//   ST_RUN      - normal issue; load-use, branch and mul/div entry are evaluated here
//   ST_MD_BUSY  - a multi-cycle mul/div owns EX and the front end is frozen
//   REG_ZERO    - architectural zero register; never a real data dependency
package hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A load in EX produces its value too late for the instruction in ID to consume.
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return mem_read && ex_rt != REG_ZERO &&
               (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID/EX hazard controller for load-use stalls, branch flushes and mul/div freezes
//   clk, rst_n          - clock and synchronous active-low reset
//   IFIDRs/IFIDRt       - source fields of the instruction in ID; IDUsesRt qualifies rt
//   IDEXRt/IDEXMemRead  - destination and load flag of the instruction in EX
//   IDEXMulDiv          - EX instruction is a multi-cycle mul/div
//   EXBranchTaken       - branch in EX resolved taken
//   PCWrite/IFIDWrite/IDEXWrite        - pipeline register enables
//   IFIDFlush/IDEXFlush/EXMEMBubble    - pipeline register flush/bubble controls
//   mdBusy              - controller is in the mul/div busy state
//   stallCount          - saturating count of cycles with PCWrite low
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             IDUsesRt,
    input  logic [4:0]       IDEXRt,
    input  logic             IDEXMemRead,
    input  logic             IDEXMulDiv,
    input  logic             EXBranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXFlush,
    output logic             EXMEMBubble,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCount
);

    localparam int             MDW     = $clog2(MD_LATENCY) + 1;
    localparam logic [MDW-1:0] MD_LAST = MDW'(MD_LATENCY - 1);
    // A single-cycle mul/div never needs to freeze the pipe.
    localparam bit             MD_EN   = MD_LATENCY > 1;

    state_t         state, state_nxt;
    logic [MDW-1:0] md_cnt, md_cnt_nxt;
    logic           lu;

    assign lu = load_use(IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, IDUsesRt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            md_cnt     <= '0;
            stallCount <= '0;
        end else begin
            state      <= state_nxt;
            md_cnt     <= md_cnt_nxt;
            stallCount <= (!PCWrite && stallCount != '1) ? stallCount + 1'b1 : stallCount;
        end
    end

    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXWrite   = 1'b1;
        IDEXFlush   = 1'b0;
        EXMEMBubble = 1'b0;
        mdBusy      = rst_n && state == ST_MD_BUSY;
        if (!rst_n) begin
            // Keep the whole pipe empty and frozen until reset is released.
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IFIDFlush   = 1'b1;
            IDEXFlush   = 1'b1;
            EXMEMBubble = 1'b1;
        end else if ((state == ST_RUN && IDEXMulDiv && MD_EN) ||
                     (state == ST_MD_BUSY && md_cnt != MD_LAST)) begin
            // Freeze everything upstream of EX; branches in EX are not yet meaningful.
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
            state_nxt   = ST_MD_BUSY;
            md_cnt_nxt  = state == ST_RUN ? MDW'(1) : md_cnt + 1'b1;
        end else begin
            // RUN without a new mul/div, or the release cycle where the held
            // instruction still shows IDEXMulDiv and must not re-trigger.
            state_nxt  = ST_RUN;
            md_cnt_nxt = '0;
            if (EXBranchTaken) begin
                // The instruction that would stall is on the wrong path anyway.
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
            end else if (lu) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXFlush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random checks of hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    IFIDRs, IFIDRt, IDEXRt;
    logic          IDUsesRt, IDEXMemRead, IDEXMulDiv, EXBranchTaken;
    logic          PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMBubble, mdBusy;
    logic [CW-1:0] stallCount;
    logic [6:0]    obs;

    int errors = 0;
    int checks = 0;
    // Model: remaining EX cycles of the mul/div occupying EX (0 = none), and the stall count.
    int m_occ = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    assign obs = {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMBubble, mdBusy};

    hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IDUsesRt(IDUsesRt),
        .IDEXRt(IDEXRt), .IDEXMemRead(IDEXMemRead), .IDEXMulDiv(IDEXMulDiv),
        .EXBranchTaken(EXBranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXWrite(IDEXWrite), .IDEXFlush(IDEXFlush), .EXMEMBubble(EXMEMBubble),
        .mdBusy(mdBusy), .stallCount(stallCount)
    );

    // Expected {PCWrite,IFIDWrite,IFIDFlush,IDEXWrite,IDEXFlush,EXMEMBubble,mdBusy}.
    function automatic logic [6:0] exp_out();
        logic hazard_lu;
        hazard_lu = IDEXMemRead && IDEXRt != 0 &&
                    (IDEXRt == IFIDRs || (IDUsesRt && IDEXRt == IFIDRt));
        if (!rst_n)                              return 7'b0011110;
        if (m_occ > 1)                           return 7'b0000011;
        if (m_occ == 0 && IDEXMulDiv && LAT > 1) return 7'b0000010;
        if (EXBranchTaken)                       return {6'b111110, m_occ == 1};
        if (hazard_lu)                           return {6'b000110, m_occ == 1};
        return {6'b110100, m_occ == 1};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic set_in(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                          input logic u, input logic [4:0] xrt, input logic mr,
                          input logic md, input logic br);
        rst_n = r; IFIDRs = rs; IFIDRt = rt; IDUsesRt = u;
        IDEXRt = xrt; IDEXMemRead = mr; IDEXMulDiv = md; EXBranchTaken = br;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic step(input string tag);
        logic [6:0] e;
        #1;
        e = exp_out();
        check({tag, "/out"}, 32'(obs), 32'(e));
        @(posedge clk);
        if (!rst_n) begin
            m_occ = 0;
            m_cnt = 0;
        end else begin
            if (!e[6]) m_cnt = m_cnt == CMAX ? CMAX : m_cnt + 1;
            if (m_occ > 0)                    m_occ = m_occ - 1;
            else if (IDEXMulDiv && LAT > 1)   m_occ = LAT - 1;
        end
        #1;
        check({tag, "/cnt"}, 32'(stallCount), 32'(m_cnt));
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int c0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step("reset0");
        step("reset1");
        #1 check("reset_forced", 32'(obs), 32'(7'b0011110));
        check("reset_cnt", 32'(stallCount), 0);

        set_in(1, 1, 2, 1, 3, 0, 0, 0);
        step("idle");

        set_in(1, 5, 0, 0, 5, 1, 0, 0);
        step("lu_stall");
        set_in(1, 5, 0, 0, 5, 0, 0, 0);
        #1 check("lu_next_defaults", 32'(obs), 32'(7'b1101000));
        step("lu_next");
        check("lu_cnt", 32'(stallCount), 1);

        set_in(1, 0, 0, 1, 0, 1, 0, 0);
        #1 check("mask_r0", 32'(PCWrite), 1);
        step("mask_r0");
        set_in(1, 1, 7, 0, 7, 1, 0, 0);
        #1 check("mask_nouse", 32'(PCWrite), 1);
        step("mask_nouse");
        set_in(1, 1, 7, 1, 7, 1, 0, 0);
        step("lu_rt");

        c0 = int'(stallCount);
        set_in(1, 1, 2, 0, 3, 0, 1, 1);
        for (int i = 0; i < LAT; i++) begin
            if (i == LAT - 1) #1 check("md_release", 32'(obs), 32'(7'b1111101));
            step("md");
        end
        set_in(1, 1, 2, 0, 3, 0, 0, 0);
        step("md_after");
        check("md_cnt3", 32'(stallCount), 32'((c0 + LAT - 1) > CMAX ? CMAX : c0 + LAT - 1));

        set_in(1, 5, 0, 0, 5, 1, 0, 1);
        #1 check("br_over_lu", 32'({PCWrite, IFIDFlush, IDEXFlush}), 32'(3'b111));
        step("br_lu");

        set_in(1, 1, 2, 0, 3, 0, 1, 0);
        step("md_rst_a");
        step("md_rst_b");
        set_in(0, 1, 2, 0, 3, 0, 1, 0);
        step("md_rst");
        set_in(1, 1, 2, 0, 3, 0, 0, 0);
        #1 check("md_rst_busy", 32'(mdBusy), 0);
        check("md_rst_cnt", 32'(stallCount), 0);
        step("md_rst_after");

        set_in(1, 3, 0, 0, 3, 1, 0, 0);
        for (int i = 0; i < 20; i++) step("sat");
        check("sat_cnt", 32'(stallCount), CMAX);

        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step("rand_rst");
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 99) >= 3,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 20);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
